// File: rtl/dma_slave_cfg_if.sv
// AXI-style bus bundle between a master and the DMA configuration slave.
// AW/W/B carry register writes, AR/R carry register reads.
interface dma_slave_cfg_if;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;

  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;

  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;

  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/dma_slave_cfg.sv
// DMA config slave: strobes/config_addr follow a W beat by one cycle; one transaction per direction, READY held low while busy.
// Optional DMA_CFG_READBACK_EN keeps readable shadows of DMASRC/DMADST/DMALEN; without it those offsets read as zero.
module dma_slave_cfg (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  dma_slave_cfg_if.slave        axi,
  output logic [31:0]           config_addr,
  output logic                  DMASRC_valid,
  output logic                  DMADST_valid,
  output logic                  DMALEN_valid,
  output logic                  DMA_enable,
  input  logic                  DMA_interrupt
);

  localparam logic [7:0] OFS_DMAEN  = 8'h00;
  localparam logic [7:0] OFS_SRC    = 8'h04;
  localparam logic [7:0] OFS_DST    = 8'h08;
  localparam logic [7:0] OFS_LEN    = 8'h0C;
  localparam logic [7:0] OFS_STATUS = 8'h10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  // ---------------- write path ----------------
  logic [1:0] w_state;
  logic [7:0] w_id_q;
  logic [7:0] w_ofs_q;
  logic       w_hs;
  logic       w_any_strb;
  logic       w_is_cfg;
  logic       w_mapped;

  assign w_hs       = (w_state == W_DATA) && axi.WVALID;
  assign w_any_strb = w_hs && (axi.WSTRB != 4'b0000);
  assign w_is_cfg   = (w_ofs_q == OFS_SRC) || (w_ofs_q == OFS_DST) || (w_ofs_q == OFS_LEN);
  assign w_mapped   = w_is_cfg || (w_ofs_q == OFS_DMAEN) || (w_ofs_q == OFS_STATUS);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state <= W_IDLE;
      w_id_q  <= '0;
      w_ofs_q <= '0;
    end else begin
      case (w_state)
        W_IDLE: if (axi.AWVALID) begin
          w_id_q  <= axi.AWID;
          w_ofs_q <= axi.AWADDR[7:0];
          w_state <= W_DATA;
        end
        W_DATA: if (axi.WVALID && axi.WLAST) w_state <= W_RESP;
        W_RESP: if (axi.BREADY) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign axi.AWREADY = (w_state == W_IDLE);
  assign axi.WREADY  = (w_state == W_DATA);
  assign axi.BVALID  = (w_state == W_RESP);
  assign axi.BID     = w_id_q;
  assign axi.BRESP   = w_mapped ? RESP_OKAY : RESP_DECERR;

  // Every beat of a burst lands on the captured offset; the address never advances.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      config_addr  <= '0;
      DMASRC_valid <= 1'b0;
      DMADST_valid <= 1'b0;
      DMALEN_valid <= 1'b0;
      DMA_enable   <= 1'b0;
    end else begin
      DMASRC_valid <= w_any_strb && (w_ofs_q == OFS_SRC);
      DMADST_valid <= w_any_strb && (w_ofs_q == OFS_DST);
      DMALEN_valid <= w_any_strb && (w_ofs_q == OFS_LEN);
      if (w_any_strb && w_is_cfg) config_addr <= axi.WDATA;
      if (w_hs && axi.WSTRB[0] && (w_ofs_q == OFS_DMAEN)) DMA_enable <= axi.WDATA[0];
    end
  end

`ifdef DMA_CFG_READBACK_EN
  logic [31:0] src_shadow;
  logic [31:0] dst_shadow;
  logic [31:0] len_shadow;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      src_shadow <= '0;
      dst_shadow <= '0;
      len_shadow <= '0;
    end else if (w_any_strb) begin
      if (w_ofs_q == OFS_SRC) src_shadow <= axi.WDATA;
      if (w_ofs_q == OFS_DST) dst_shadow <= axi.WDATA;
      if (w_ofs_q == OFS_LEN) len_shadow <= axi.WDATA;
    end
  end
`endif

  // ---------------- read path ----------------
  logic [0:0]  r_state;
  logic [7:0]  r_id_q;
  logic [7:0]  r_ofs_q;
  logic [3:0]  r_len_q;
  logic [3:0]  r_cnt;
  logic [31:0] r_data_q;
  logic [1:0]  r_resp_q;
  logic        r_last;
  logic [7:0]  rd_ofs;
  logic [31:0] rd_value;
  logic [1:0]  rd_resp;

  assign rd_ofs = (r_state == R_IDLE) ? axi.ARADDR[7:0] : r_ofs_q;

  always_comb begin
    rd_value = '0;
    rd_resp  = RESP_OKAY;
    case (rd_ofs)
      OFS_STATUS: rd_value = {30'b0, DMA_interrupt, DMA_enable};
`ifdef DMA_CFG_READBACK_EN
      OFS_DMAEN:  rd_value = {31'b0, DMA_enable};
      OFS_SRC:    rd_value = src_shadow;
      OFS_DST:    rd_value = dst_shadow;
      OFS_LEN:    rd_value = len_shadow;
`else
      OFS_DMAEN, OFS_SRC, OFS_DST, OFS_LEN: rd_value = '0;
`endif
      default:    rd_resp  = RESP_DECERR;
    endcase
  end

  assign r_last = (r_state == R_DATA) && (r_cnt == r_len_q);

  // Data is sampled at acceptance and after each beat, so a stalled beat never changes
  // and a read racing a register write sees the pre-write value.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state  <= R_IDLE;
      r_id_q   <= '0;
      r_ofs_q  <= '0;
      r_len_q  <= '0;
      r_cnt    <= '0;
      r_data_q <= '0;
      r_resp_q <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: if (axi.ARVALID) begin
          r_id_q   <= axi.ARID;
          r_ofs_q  <= axi.ARADDR[7:0];
          r_len_q  <= axi.ARLEN;
          r_cnt    <= '0;
          r_data_q <= rd_value;
          r_resp_q <= rd_resp;
          r_state  <= R_DATA;
        end
        R_DATA: if (axi.RREADY) begin
          if (r_last) begin
            r_state <= R_IDLE;
          end else begin
            r_cnt    <= r_cnt + 4'd1;
            r_data_q <= rd_value;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign axi.ARREADY = (r_state == R_IDLE);
  assign axi.RVALID  = (r_state == R_DATA);
  assign axi.RLAST   = r_last;
  assign axi.RID     = r_id_q;
  assign axi.RDATA   = r_data_q;
  assign axi.RRESP   = r_resp_q;

  logic unused_ok;
  assign unused_ok = ^{axi.AWADDR[31:8], axi.AWLEN, axi.AWSIZE, axi.AWBURST,
                       axi.ARADDR[31:8], axi.ARSIZE, axi.ARBURST};

endmodule

// File: tb/tb_dma_slave_cfg.sv
// Scoreboard bench for dma_slave_cfg: directed writes/reads push expected B, R and strobe
// events into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_dma_slave_cfg;

`ifdef DMA_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        ACLK;
  logic        ARESETn;
  logic [31:0] config_addr;
  logic        DMASRC_valid, DMADST_valid, DMALEN_valid;
  logic        DMA_enable;
  logic        DMA_interrupt;

  dma_slave_cfg_if ifc ();

  dma_slave_cfg dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .axi           (ifc),
    .config_addr   (config_addr),
    .DMASRC_valid  (DMASRC_valid),
    .DMADST_valid  (DMADST_valid),
    .DMALEN_valid  (DMALEN_valid),
    .DMA_enable    (DMA_enable),
    .DMA_interrupt (DMA_interrupt)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      exp_r[$];
  logic [9:0]  exp_b[$];
  logic [34:0] exp_cfg[$];

  int n_tests = 0;
  int n_fail  = 0;
  bit bvalid_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected event %0h with empty scoreboard", name, act);
  endtask

  // ---------------- monitor ----------------
  logic   whs_prev;
  logic   r_stall_prev;
  rbeat_t r_prev;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      whs_prev     <= 1'b0;
      r_stall_prev <= 1'b0;
    end else begin
      if (ifc.BVALID) bvalid_seen = 1'b1;
      if (ifc.BVALID && ifc.BREADY) begin
        if (exp_b.size() == 0) unexpected("b_resp", {ifc.BID, ifc.BRESP});
        else check("b_resp", {ifc.BID, ifc.BRESP}, exp_b.pop_front());
      end
      if (ifc.RVALID && ifc.RREADY) begin
        if (exp_r.size() == 0) unexpected("r_beat", {ifc.RID, ifc.RDATA, ifc.RRESP, ifc.RLAST});
        else check("r_beat", {ifc.RID, ifc.RDATA, ifc.RRESP, ifc.RLAST}, exp_r.pop_front());
      end
      if (r_stall_prev)
        check("r_hold", {ifc.RVALID, ifc.RID, ifc.RDATA, ifc.RRESP, ifc.RLAST}, {1'b1, r_prev});
      if (DMASRC_valid || DMADST_valid || DMALEN_valid) begin
        if (exp_cfg.size() == 0)
          unexpected("cfg_strobe", {DMASRC_valid, DMADST_valid, DMALEN_valid, config_addr});
        else
          check("cfg_strobe", {whs_prev, DMASRC_valid, DMADST_valid, DMALEN_valid, config_addr},
                {1'b1, exp_cfg.pop_front()});
      end
      whs_prev     <= ifc.WVALID && ifc.WREADY;
      r_stall_prev <= ifc.RVALID && !ifc.RREADY;
      r_prev       <= {ifc.RID, ifc.RDATA, ifc.RRESP, ifc.RLAST};
    end
  end

  // ---------------- bus tasks ----------------
  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    bit ok = 1'b0;
    int cyc = 0;
    ifc.AWID = id; ifc.AWADDR = addr; ifc.AWLEN = len;
    ifc.AWSIZE = 3'd2; ifc.AWBURST = 2'd1; ifc.AWVALID = 1'b1;
    while (!ok && cyc < 32) begin
      @(negedge ACLK); ok = ifc.AWREADY;
      @(posedge ACLK); #1; cyc++;
    end
    ifc.AWVALID = 1'b0;
    check("aw_accept", ok, 1'b1);
  endtask

  task automatic do_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    bit ok = 1'b0;
    int cyc = 0;
    ifc.WDATA = data; ifc.WSTRB = strb; ifc.WLAST = last; ifc.WVALID = 1'b1;
    while (!ok && cyc < 32) begin
      @(negedge ACLK); ok = ifc.WREADY;
      @(posedge ACLK); #1; cyc++;
    end
    ifc.WVALID = 1'b0; ifc.WLAST = 1'b0;
    check("w_accept", ok, 1'b1);
  endtask

  task automatic do_b();
    bit ok = 1'b0;
    int cyc = 0;
    ifc.BREADY = 1'b1;
    while (!ok && cyc < 32) begin
      @(negedge ACLK); ok = ifc.BVALID;
      @(posedge ACLK); #1; cyc++;
    end
    ifc.BREADY = 1'b0;
    check("b_seen", ok, 1'b1);
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len);
    bit ok = 1'b0;
    int cyc = 0;
    ifc.ARID = id; ifc.ARADDR = addr; ifc.ARLEN = len;
    ifc.ARSIZE = 3'd2; ifc.ARBURST = 2'd1; ifc.ARVALID = 1'b1;
    while (!ok && cyc < 32) begin
      @(negedge ACLK); ok = ifc.ARREADY;
      @(posedge ACLK); #1; cyc++;
    end
    ifc.ARVALID = 1'b0;
    check("ar_accept", ok, 1'b1);
  endtask

  task automatic do_r(input bit toggle);
    bit done = 1'b0;
    int cyc = 0;
    ifc.RREADY = 1'b1;
    while (!done && cyc < 64) begin
      @(negedge ACLK);
      if (ifc.RVALID && ifc.RREADY && ifc.RLAST) done = 1'b1;
      @(posedge ACLK); #1; cyc++;
      if (toggle) ifc.RREADY = !ifc.RREADY;
    end
    ifc.RREADY = 1'b0;
    check("r_done", done, 1'b1);
  endtask

  task automatic write1(input logic [7:0] id, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb);
    do_aw(id, addr, 4'd0);
    do_w(data, strb, 1'b1);
    do_b();
  endtask

  task automatic read1(input logic [7:0] id, input logic [31:0] addr);
    do_ar(id, addr, 4'd0);
    do_r(1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    ARESETn = 1'b0; DMA_interrupt = 1'b0;
    ifc.AWID = '0; ifc.AWADDR = '0; ifc.AWLEN = '0; ifc.AWSIZE = '0; ifc.AWBURST = '0; ifc.AWVALID = 1'b0;
    ifc.WDATA = '0; ifc.WSTRB = '0; ifc.WLAST = 1'b0; ifc.WVALID = 1'b0; ifc.BREADY = 1'b0;
    ifc.ARID = '0; ifc.ARADDR = '0; ifc.ARLEN = '0; ifc.ARSIZE = '0; ifc.ARBURST = '0; ifc.ARVALID = 1'b0;
    ifc.RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_handshake", {ifc.AWREADY, ifc.ARREADY, ifc.WREADY, ifc.BVALID, ifc.RVALID, ifc.RLAST},
          6'b110000);
    check("rst_cfg", {DMASRC_valid, DMADST_valid, DMALEN_valid, DMA_enable, config_addr}, 36'h0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;

    // single SRC write
    exp_cfg.push_back({3'b100, 32'h0001_0000});
    exp_b.push_back({8'h11, 2'b00});
    write1(8'h11, 32'h04, 32'h0001_0000, 4'hF);
    check("cfg_hold_src", config_addr, 32'h0001_0000);

    exp_cfg.push_back({3'b010, 32'hA5A5_0008});
    exp_b.push_back({8'h12, 2'b00});
    write1(8'h12, 32'h08, 32'hA5A5_0008, 4'hF);

    exp_cfg.push_back({3'b001, 32'h0000_0040});
    exp_b.push_back({8'h13, 2'b00});
    write1(8'h13, 32'h0C, 32'h0000_0040, 4'hF);

    // zero strobes: response only, no load
    exp_b.push_back({8'h18, 2'b00});
    write1(8'h18, 32'h0C, 32'hDEAD_BEEF, 4'h0);
    check("cfg_hold_nostrb", config_addr, 32'h0000_0040);

    // enable then STATUS readback
    exp_b.push_back({8'h21, 2'b00});
    write1(8'h21, 32'h00, 32'h0000_0001, 4'h1);
    check("dma_enable_set", DMA_enable, 1'b1);
    DMA_interrupt = 1'b1;
    exp_r.push_back({8'h31, 32'h0000_0003, 2'b00, 1'b1});
    read1(8'h31, 32'h10);

    // STATUS is read-only
    exp_b.push_back({8'h23, 2'b00});
    write1(8'h23, 32'h10, 32'h0000_0000, 4'hF);
    check("status_wr_noeffect", DMA_enable, 1'b1);

    // unmapped offset
    exp_b.push_back({8'h22, 2'b11});
    write1(8'h22, 32'h20, 32'h1111_2222, 4'hF);
    exp_r.push_back({8'h32, 32'h0, 2'b11, 1'b1});
    read1(8'h32, 32'h20);

    // 4-beat LEN read with RREADY toggling
    for (int i = 0; i < 4; i++)
      exp_r.push_back({8'h33, (RB ? 32'h0000_0040 : 32'h0), 2'b00, (i == 3)});
    do_ar(8'h33, 32'h0C, 4'd3);
    do_r(1'b1);

    exp_r.push_back({8'h35, (RB ? 32'h0000_0001 : 32'h0), 2'b00, 1'b1});
    read1(8'h35, 32'h00);

    // 2-beat burst to SRC: both beats hit the same register
    exp_cfg.push_back({3'b100, 32'h0000_1000});
    exp_cfg.push_back({3'b100, 32'h0000_2000});
    exp_b.push_back({8'h16, 2'b00});
    do_aw(8'h16, 32'h04, 4'd1);
    do_w(32'h0000_1000, 4'hF, 1'b0);
    do_w(32'h0000_2000, 4'hF, 1'b1);
    do_b();

    // simultaneous AW and AR on DMADST
    exp_cfg.push_back({3'b010, 32'h1234_5678});
    exp_b.push_back({8'h14, 2'b00});
    exp_r.push_back({8'h34, (RB ? 32'hA5A5_0008 : 32'h0), 2'b00, 1'b1});
    ifc.AWID = 8'h14; ifc.AWADDR = 32'h08; ifc.AWLEN = 4'd0; ifc.AWVALID = 1'b1;
    ifc.ARID = 8'h34; ifc.ARADDR = 32'h08; ifc.ARLEN = 4'd0; ifc.ARVALID = 1'b1;
    @(negedge ACLK);
    check("aw_ar_same_cycle", {ifc.AWREADY, ifc.ARREADY}, 2'b11);
    @(posedge ACLK); #1;
    ifc.AWVALID = 1'b0; ifc.ARVALID = 1'b0;
    fork
      begin
        do_w(32'h1234_5678, 4'hF, 1'b1);
        do_b();
      end
      do_r(1'b0);
    join

    // reset during W_DATA abandons the write
    do_aw(8'h15, 32'h04, 4'd0);
    check("in_w_data", {ifc.WREADY, ifc.AWREADY}, 2'b10);
    bvalid_seen = 1'b0;
    ARESETn = 1'b0;
    #1;
    check("rst_mid_write", {DMA_enable, ifc.WREADY, ifc.AWREADY, ifc.BVALID, config_addr},
          {1'b0, 1'b0, 1'b1, 1'b0, 32'h0});
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    check("awready_after_rst", {ifc.AWREADY, ifc.ARREADY, ifc.WREADY}, 3'b110);
    repeat (4) @(negedge ACLK);
    check("no_bvalid_after_rst", bvalid_seen, 1'b0);
    @(posedge ACLK); #1;
    exp_r.push_back({8'h36, 32'h0000_0002, 2'b00, 1'b1});
    read1(8'h36, 32'h10);

    repeat (3) @(posedge ACLK);
    check("exp_b_drained", exp_b.size(), 0);
    check("exp_r_drained", exp_r.size(), 0);
    check("exp_cfg_drained", exp_cfg.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_slave_cfg.md
DMA_SLAVE_CFG -- requirements
Module: dma_slave_cfg

Interface
REQ-001 Parameters: none; widths fixed: ID 8, ADDR 32, LEN 4, SIZE 3, BURST 2, DATA 32, STRB 4, RESP 2.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Ports SHALL be:
- ACLK  in  1  clock
- ARESETn  in  1  async active-low reset
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  8/32/4/3/2  write address
- AWVALID in 1, AWREADY out 1  write address handshake
- WDATA/WSTRB/WLAST  in  32/4/1  write data
- WVALID in 1, WREADY out 1  write data handshake
- BID/BRESP out 8/2, BVALID out 1, BREADY in 1  write response
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  8/32/4/3/2  read address
- ARVALID in 1, ARREADY out 1  read address handshake
- RID/RDATA/RRESP/RLAST out 8/32/2/1, RVALID out 1, RREADY in 1  read data
- config_addr  out  32  value for DMA config registers
- DMASRC_valid/DMADST_valid/DMALEN_valid  out  1 each  one-cycle load strobes
- DMA_enable  out  1  DMA run enable
- DMA_interrupt  in  1  DMA completion, from the DMA engine

Function
REQ-004 Register map by ADDR[7:0]: 0x00 DMAEN (bit0), 0x04 DMASRC, 0x08 DMADST, 0x0C DMALEN, 0x10 STATUS (read-only: bit0 DMA_enable, bit1 DMA_interrupt); any other offset SHALL be unmapped.
REQ-005 Write FSM SHALL use states W_IDLE, W_DATA, W_RESP; AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
REQ-006 W_IDLE->W_DATA on AW handshake, capturing AWID and AWADDR; W_DATA->W_RESP on W handshake with WLAST=1; W_RESP->W_IDLE on BVALID&&BREADY.
REQ-007 All beats of a burst SHALL target the captured address (no increment), regardless of AWBURST/AWSIZE.
REQ-008 A W handshake with WSTRB!=0 to DMASRC/DMADST/DMALEN SHALL, on the next cycle, drive config_addr=WDATA and pulse the matching strobe for exactly one cycle.
REQ-009 A W handshake with WSTRB[0]=1 to DMAEN SHALL update DMA_enable<=WDATA[0] at the next edge; DMA_enable SHALL change only by software write.
REQ-010 Writes to STATUS or unmapped offsets SHALL have no side effect; BRESP SHALL be 2'b11 (DECERR) for unmapped, 2'b00 otherwise, including STATUS; BID=captured AWID.
REQ-011 Read FSM SHALL use states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE; R_IDLE->R_DATA on AR handshake capturing ARID, ARADDR, ARLEN; beat counter cleared.
REQ-012 In R_DATA RVALID=1; RLAST=1 when beat counter==ARLEN; counter increments per R handshake; R_DATA->R_IDLE on handshake with RLAST=1 (ARLEN=15 gives 16 beats).
REQ-013 RID=captured ARID; RRESP=2'b11 for unmapped offsets with RDATA=0, else 2'b00.
REQ-014 Read and write FSMs SHALL be independent; simultaneous AW and AR SHALL both be accepted the same cycle.
REQ-015 A read in the same cycle as a write's register update SHALL return the pre-update value.
REQ-016 Outputs SHALL hold while VALID is high and READY low (no retraction, no change).

Reset
REQ-017 On ARESETn=0 both FSMs SHALL go to IDLE immediately; AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, all strobes 0, DMA_enable=0, config_addr=0, shadows=0; any in-flight transaction SHALL be abandoned without response.

Configuration
REQ-018 Macro DMA_CFG_READBACK_EN: defined -> block SHALL keep 32-bit shadow copies of DMASRC/DMADST/DMALEN updated with the strobes, and reads of 0x00-0x0C SHALL return register contents (DMAEN in bit0).
REQ-019 Not defined -> no shadows; reads of 0x00-0x0C SHALL return RDATA=0 with RRESP=2'b00; STATUS readback unaffected.

Verification
REQ-020 Single write AWADDR=0x04, WDATA=0x0001_0000, WLAST=1 -> next cycle DMASRC_valid=1 one cycle, config_addr=0x0001_0000; BRESP=00, BID=AWID.
REQ-021 Write 0x00 WDATA=1 then read 0x10 with DMA_interrupt=1 -> DMA_enable=1; RDATA=0x3, RLAST=1, RRESP=00.
REQ-022 Write to 0x20 -> no strobe, BRESP=11; read 0x20 ARLEN=0 -> RDATA=0, RRESP=11.
REQ-023 Read 0x0C ARLEN=3 with RREADY toggled 1/0 -> exactly 4 beats, RLAST only on 4th, RDATA stable while stalled; value=last DMALEN write with DMA_CFG_READBACK_EN, 0 without.
REQ-024 Simultaneous AW(0x08) and AR(0x08) in one cycle -> both accepted; read returns old DMADST, DMADST_valid pulses once.
REQ-025 ARESETn low during W_DATA after DMAEN=1 -> DMA_enable=0, BVALID never asserted, AWREADY=1 after release.
